max10_adc_sequencer: RTL and testbench
======================================

# max10_adc_sequencer

Drives the command port of the MAX 10 ADC wrapper and consumes its response port. Scans a channel-enable mask in ascending order, issuing one conversion command at a time. Writes each returned sample into a per-channel result register file, optionally averaged. Downstream logic reads samples through a registered read port or a streaming sample strobe.

## Interface
- NUM_CH, 17 — ADC channel count (0–16, channel 17+ never issued)
- AVG_LOG2, 2 — log2 of samples averaged per result (used only with averaging compiled in)

- clock_clk  in  1  system clock, same as ADC wrapper clock_clk
- reset_sink_reset  in  1  synchronous, active-high reset
- enable  in  1  run continuous scans while high
- channel_mask  in  NUM_CH  bit n = convert channel n; latched at scan start
- command_valid  out  1  command handshake valid
- command_channel  out  5  channel to convert
- command_startofpacket  out  1  first command of a scan
- command_endofpacket  out  1  last command of a scan
- command_ready  in  1  ADC accepts command
- response_valid  in  1  sample present (single-cycle, no backpressure)
- response_channel  in  5  channel of sample
- response_data  in  12  raw sample
- response_startofpacket / response_endofpacket  in  1 each  ignored (reserved)
- rd_channel  in  5  result register select
- rd_data  out  12  result for rd_channel, one-cycle latency
- sample_valid  out  1  one-cycle strobe, new result written
- sample_channel  out  5  channel of written result
- sample_data  out  12  value written
- scan_done  out  1  one-cycle pulse, scan complete
- error  out  1  sticky channel-mismatch flag
- error_clear  in  1  clears error

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if enable && channel_mask != 0, latch the mask into scan_mask, select the lowest set bit, and go to ISSUE. A zero mask keeps the block in IDLE.
- ISSUE: command_valid=1 with the current channel. Stay until command_ready. command_valid, channel, sop and eop are held stable until accepted. sop=1 on the first channel of the scan; eop=1 when no higher bit is set in scan_mask. On accept, go to WAIT.
- WAIT: on response_valid:
  - Channel equals expected: write the result.
  - Channel differs: set error, discard data, and treat the conversion as finished.
  - Then the next set bit above the current one selects the next channel → ISSUE.
  - If none remains, pulse scan_done. Go to IDLE; this re-scans on the next cycle if enable is still high.
- enable low mid-scan: the current scan completes; the next scan does not start.
- Only one command is outstanding at a time.
- response_valid outside WAIT is ignored: no write, no error.
- error_clear and a new error in the same cycle: error stays 1.
- Results: NUM_CH×12 register file; rd_channel ≥ NUM_CH returns 0.

## Timing
- Reset values:
  - state = IDLE
  - command_valid, sop, eop, sample_valid, scan_done, error = 0
  - command_channel, sample_channel, sample_data, rd_data = 0
  - all result registers and accumulators = 0
- IDLE→ISSUE: one cycle. command_valid is high in the cycle after enable is sampled.
- Accept: command_valid && command_ready at an edge → WAIT from the next cycle. command_valid drops in that next cycle.
- response_valid at edge k → sample_valid, the register write and scan_done (if last) are visible in cycle k+1. command_valid for the next channel is also high in cycle k+1.
- rd_data reflects the register contents one cycle after rd_channel. A write and a read of the same channel in the same cycle returns the old value.
- Reset asserted mid-operation: return to the reset state on the next edge. A response arriving later is ignored.

## Configuration
- MAX10_ADC_SEQ_AVG_EN defined:
  - Each channel keeps a (12+AVG_LOG2)-bit accumulator and an AVG_LOG2-bit count.
  - On the 2^AVG_LOG2-th sample, the result is acc >> AVG_LOG2 (truncated) and sample_valid pulses. The accumulator and count then clear.
  - Earlier samples only accumulate, with no sample_valid.
  - Mismatched samples never accumulate.
- MAX10_ADC_SEQ_AVG_EN undefined: every matching sample writes directly and pulses sample_valid. AVG_LOG2 is unused and the accumulators are not built.

## Structure
- Package max10_adc_seq_pkg:
  - CH_W=5, DATA_W=12, NUM_CH_MAX=17
  - state enum {IDLE, ISSUE, WAIT}
- Sub-module max10_adc_seq_next_ch: combinational priority finder. Inputs are the mask and current channel; outputs are the next set-bit index, a found flag, and an is-last flag.

## Test plan
- Mask 0x00005, enable=1, command_ready always 1, ADC echoes the channel with data 0x123/0x456 → commands ch0 (sop=1, eop=0) then ch2 (sop=0, eop=1). sample_valid twice; rd_data(0)=0x123, rd_data(2)=0x456; scan_done with the ch2 sample.
- command_ready held low for 5 cycles → command_valid/channel/sop/eop stable for all 5 cycles; exactly one command accepted.
- Response with channel 3 while expecting 2 → error=1, register 2 unchanged, scan continues. error_clear → error=0.
- Mask=0 with enable=1 → no command_valid for 100 cycles.
- Reset asserted while in WAIT, followed by a stray response_valid → all outputs at reset values, no write, no error.
- With averaging, AVG_LOG2=2, ch1 samples 10, 11, 12, 14 → exactly one sample_valid, with data 11.

Source files
------------

// File: rtl/max10_adc_seq_pkg.sv
// Shared widths, limits and FSM state encoding for the MAX 10 ADC sequencer.
// Imported by the interface, the next-channel finder and the top.
package max10_adc_seq_pkg;

    localparam int CH_W       = 5;
    localparam int DATA_W     = 12;
    localparam int NUM_CH_MAX = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/max10_adc_sequencer_if.sv
// Command/response streams between the sequencer (master) and the MAX 10 ADC wrapper (slave).
interface max10_adc_sequencer_if;
    import max10_adc_seq_pkg::*;

    logic              command_valid;
    logic [CH_W-1:0]   command_channel;
    logic              command_startofpacket;
    logic              command_endofpacket;
    logic              command_ready;
    logic              response_valid;
    logic [CH_W-1:0]   response_channel;
    logic [DATA_W-1:0] response_data;
    logic              response_startofpacket;
    logic              response_endofpacket;

    modport master (
        output command_valid, command_channel, command_startofpacket, command_endofpacket,
        input  command_ready,
        input  response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket
    );

    modport slave (
        input  command_valid, command_channel, command_startofpacket, command_endofpacket,
        output command_ready,
        output response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket
    );

endinterface

// File: rtl/max10_adc_seq_next_ch.sv
// Priority finder: first set mask bit at/above 0 (from_start) or strictly above i_cur,
// plus whether any set bit remains above the one found.
module max10_adc_seq_next_ch
    import max10_adc_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_MAX
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W-1:0]   i_cur,
    input  logic              i_from_start,
    output logic [CH_W-1:0]   o_next,
    output logic              o_found,
    output logic              o_is_last
);

    logic [CH_W-1:0] w_next;
    logic            w_found;
    logic            w_is_last;

    // Ascending scan for the next candidate, then a look-ahead for any higher set bit
    always_comb begin
        w_next    = {CH_W{1'b0}};
        w_found   = 1'b0;
        w_is_last = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_mask[i] && !w_found && (i_from_start || (i > int'(i_cur)))) begin
                w_found = 1'b1;
                w_next  = CH_W'(i);
            end else begin
                w_found = w_found;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (w_found && i_mask[j] && (j > int'(w_next))) begin
                w_is_last = 1'b0;
            end else begin
                w_is_last = w_is_last;
            end
        end
    end

    assign o_next    = w_next;
    assign o_found   = w_found;
    assign o_is_last = w_is_last;

endmodule

// File: rtl/max10_adc_sequencer.sv
// Scans an enabled-channel mask, issues one ADC conversion at a time and stores results.
// Optional per-channel averaging is compiled in with MAX10_ADC_SEQ_AVG_EN.
module max10_adc_sequencer
    import max10_adc_seq_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_MAX,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clock_clk,
    input  logic                  reset_sink_reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     channel_mask,
    max10_adc_sequencer_if.master adc,
    input  logic [CH_W-1:0]       rd_channel,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  sample_valid,
    output logic [CH_W-1:0]       sample_channel,
    output logic [DATA_W-1:0]     sample_data,
    output logic                  scan_done,
    output logic                  error,
    input  logic                  error_clear
);

    state_e            r_state, w_state_nxt;
    logic [NUM_CH-1:0] r_scan_mask, w_find_mask;
    logic [CH_W-1:0]   r_ch, w_ch_nxt, w_next_ch;
    logic              r_sop, w_sop_nxt, r_eop, w_eop_nxt;
    logic              r_cmd_valid, r_scan_done, w_scan_done_nxt, w_latch;
    logic              w_found, w_is_last, w_from_start;
    logic              w_resp, w_match, w_mismatch, r_error;
    logic [DATA_W-1:0] r_res [NUM_CH];
    logic [DATA_W-1:0] r_rd_data, r_sample_data;
    logic [CH_W-1:0]   r_sample_channel;
    logic              r_sample_valid;

    max10_adc_seq_next_ch #(.NUM_CH(NUM_CH)) u_next_ch (
        .i_mask       (w_find_mask),
        .i_cur        (r_ch),
        .i_from_start (w_from_start),
        .o_next       (w_next_ch),
        .o_found      (w_found),
        .o_is_last    (w_is_last)
    );

    // In IDLE the finder looks at the live mask; during a scan it walks the latched copy
    always_comb begin
        w_find_mask  = r_scan_mask;
        w_from_start = 1'b0;
        if (r_state == IDLE) begin
            w_find_mask  = channel_mask;
            w_from_start = 1'b1;
        end else begin
            w_find_mask  = r_scan_mask;
            w_from_start = 1'b0;
        end
    end

    assign w_resp     = (r_state == WAIT) && adc.response_valid;
    assign w_match    = w_resp && (adc.response_channel == r_ch);
    assign w_mismatch = w_resp && (adc.response_channel != r_ch);

    // Next-state and next-command computation
    always_comb begin
        w_state_nxt     = r_state;
        w_ch_nxt        = r_ch;
        w_sop_nxt       = r_sop;
        w_eop_nxt       = r_eop;
        w_latch         = 1'b0;
        w_scan_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_found) begin
                    w_state_nxt = ISSUE;
                    w_latch     = 1'b1;
                    w_ch_nxt    = w_next_ch;
                    w_sop_nxt   = 1'b1;
                    w_eop_nxt   = w_is_last;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (adc.command_ready) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            WAIT: begin
                // A mismatched response still finishes the conversion
                if (adc.response_valid) begin
                    if (w_found) begin
                        w_state_nxt = ISSUE;
                        w_ch_nxt    = w_next_ch;
                        w_sop_nxt   = 1'b0;
                        w_eop_nxt   = w_is_last;
                    end else begin
                        w_state_nxt     = IDLE;
                        w_scan_done_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, command outputs, scan pulse and sticky error
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_state     <= IDLE;
            r_scan_mask <= {NUM_CH{1'b0}};
            r_ch        <= {CH_W{1'b0}};
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_scan_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ch        <= w_ch_nxt;
            r_sop       <= w_sop_nxt;
            r_eop       <= w_eop_nxt;
            r_cmd_valid <= (w_state_nxt == ISSUE);
            r_scan_done <= w_scan_done_nxt;
            if (w_latch) begin
                r_scan_mask <= channel_mask;
            end else begin
                r_scan_mask <= r_scan_mask;
            end
            if (w_mismatch) begin
                r_error <= 1'b1;
            end else if (error_clear) begin
                r_error <= 1'b0;
            end else begin
                r_error <= r_error;
            end
        end
    end

`ifdef MAX10_ADC_SEQ_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]    r_acc [NUM_CH];
    logic [AVG_LOG2-1:0] r_cnt [NUM_CH];
    logic [ACC_W-1:0]    w_sum;
    logic                w_avg_done;
    logic                w_unused;

    assign w_sum      = r_acc[r_ch] + ACC_W'(adc.response_data);
    assign w_avg_done = &r_cnt[r_ch];
    assign w_unused   = &{1'b0, adc.response_startofpacket, adc.response_endofpacket};

    // Accumulate matching samples; publish the truncated mean on the last of each group
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_res[i] <= {DATA_W{1'b0}};
                r_acc[i] <= {ACC_W{1'b0}};
                r_cnt[i] <= {AVG_LOG2{1'b0}};
            end
            r_sample_valid   <= 1'b0;
            r_sample_channel <= {CH_W{1'b0}};
            r_sample_data    <= {DATA_W{1'b0}};
        end else if (w_match) begin
            if (w_avg_done) begin
                r_res[r_ch]      <= w_sum[ACC_W-1:AVG_LOG2];
                r_acc[r_ch]      <= {ACC_W{1'b0}};
                r_cnt[r_ch]      <= {AVG_LOG2{1'b0}};
                r_sample_valid   <= 1'b1;
                r_sample_channel <= r_ch;
                r_sample_data    <= w_sum[ACC_W-1:AVG_LOG2];
            end else begin
                r_acc[r_ch]    <= w_sum;
                r_cnt[r_ch]    <= r_cnt[r_ch] + AVG_LOG2'(1'b1);
                r_sample_valid <= 1'b0;
            end
        end else begin
            r_sample_valid <= 1'b0;
        end
    end
`else
    logic w_unused;

    assign w_unused = &{1'b0, adc.response_startofpacket, adc.response_endofpacket, (AVG_LOG2 != 0)};

    // Every matching sample lands directly in the result file
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_res[i] <= {DATA_W{1'b0}};
            end
            r_sample_valid   <= 1'b0;
            r_sample_channel <= {CH_W{1'b0}};
            r_sample_data    <= {DATA_W{1'b0}};
        end else if (w_match) begin
            r_res[r_ch]      <= adc.response_data;
            r_sample_valid   <= 1'b1;
            r_sample_channel <= r_ch;
            r_sample_data    <= adc.response_data;
        end else begin
            r_sample_valid <= 1'b0;
        end
    end
`endif

    // Registered read port; out-of-range channels read as zero
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_rd_data <= {DATA_W{1'b0}};
        end else if (int'(rd_channel) < NUM_CH) begin
            r_rd_data <= r_res[rd_channel];
        end else begin
            r_rd_data <= {DATA_W{1'b0}};
        end
    end

    assign adc.command_valid         = r_cmd_valid;
    assign adc.command_channel       = r_ch;
    assign adc.command_startofpacket = r_sop;
    assign adc.command_endofpacket   = r_eop;
    assign rd_data                   = r_rd_data;
    assign sample_valid              = r_sample_valid;
    assign sample_channel            = r_sample_channel;
    assign sample_data               = r_sample_data;
    assign scan_done                 = r_scan_done;
    assign error                     = r_error;

endmodule

// File: tb/tb_max10_adc_sequencer.sv
// Scoreboard bench for max10_adc_sequencer: a bus process plays the ADC and checks outputs
// against a mask-order / per-channel-result model; honours MAX10_ADC_SEQ_AVG_EN.
module tb_max10_adc_sequencer;
    import max10_adc_seq_pkg::*;

    localparam int NCH = 17;
    localparam int AL2 = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            error_clear = 1'b0;
    logic [NCH-1:0]  channel_mask = '0;
    logic [4:0]      rd_channel = '0;
    logic [11:0]     rd_data, sample_data;
    logic [4:0]      sample_channel;
    logic            sample_valid, scan_done, error;

    max10_adc_sequencer_if adc();

    max10_adc_sequencer #(.NUM_CH(NCH), .AVG_LOG2(AL2)) dut (
        .clock_clk        (clk),
        .reset_sink_reset (rst),
        .enable           (enable),
        .channel_mask     (channel_mask),
        .adc              (adc),
        .rd_channel       (rd_channel),
        .rd_data          (rd_data),
        .sample_valid     (sample_valid),
        .sample_channel   (sample_channel),
        .sample_data      (sample_data),
        .scan_done        (scan_done),
        .error            (error),
        .error_clear      (error_clear)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] ch; logic [11:0] d; } samp_t;

    int total = 0, bad = 0;
    samp_t exp_q[$];
    logic [11:0] mdl_res[NCH];
    int macc[NCH], mcnt[NCH];
    int chs[$];
    int cmd_idx = 0;
    int ready_mode = 1;
    bit hold_resp = 0, stray = 0, inject = 0, fixed = 0;
    int inject_ch = 0;
    logic [11:0] fixed_q[$];
    bit pend = 0, pend_eop = 0, exp_done = 0;
    int pend_dly = 0;
    logic [4:0] pend_ch = '0;
    int done_cnt = 0, samp_cnt = 0, acc_cnt = 0, valid_cycles = 0, push_cnt = 0;
    int stop_at = -1;
    logic [11:0] last_sdata = '0;
    bit prev_stall = 0, prev_sop = 0, prev_eop = 0;
    logic [4:0] prev_ch = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: a matching sample becomes a result either directly or per group of 2^AL2
    task automatic model_sample(input logic [4:0] c, input logic [11:0] d);
        samp_t s;
`ifdef MAX10_ADC_SEQ_AVG_EN
        macc[c] += int'(d);
        mcnt[c]++;
        if (mcnt[c] == (1 << AL2)) begin
            s.ch = c; s.d = 12'(macc[c] >> AL2);
            exp_q.push_back(s); push_cnt++;
            mdl_res[c] = s.d;
            macc[c] = 0; mcnt[c] = 0;
        end
`else
        s.ch = c; s.d = d;
        exp_q.push_back(s); push_cnt++;
        mdl_res[c] = d;
`endif
    endtask

    // ADC/bus process: checks this cycle's outputs, drives response and ready on the negedge
    initial begin
        samp_t s;
        logic [11:0] d;
        logic [4:0] rch;
        adc.command_ready = 1'b0;
        adc.response_valid = 1'b0;
        adc.response_channel = '0;
        adc.response_data = '0;
        adc.response_startofpacket = 1'b0;
        adc.response_endofpacket = 1'b0;
        forever begin
            @(negedge clk);
            adc.response_valid = 1'b0;
            if (rst) begin
                pend = 0; prev_stall = 0; exp_done = 0;
            end else begin
                if (sample_valid) begin
                    samp_cnt++;
                    last_sdata = sample_data;
                    if (exp_q.size() == 0) begin
                        check("sample_unexpected", 32'(sample_valid), 32'd0);
                    end else begin
                        s = exp_q.pop_front();
                        check("sample_ch", 32'(sample_channel), 32'(s.ch));
                        check("sample_data", 32'(sample_data), 32'(s.d));
                    end
                end
                if (scan_done || exp_done) check("scan_done", 32'(scan_done), 32'(exp_done));
                exp_done = 0;
                if (scan_done) begin
                    done_cnt++;
                    if (done_cnt == stop_at) enable = 1'b0;
                end
                if (adc.command_valid) valid_cycles++;
                if (prev_stall) begin
                    check("stall_valid", 32'(adc.command_valid), 32'd1);
                    check("stall_ch", 32'(adc.command_channel), 32'(prev_ch));
                    check("stall_sop", 32'(adc.command_startofpacket), 32'(prev_sop));
                    check("stall_eop", 32'(adc.command_endofpacket), 32'(prev_eop));
                end
                if (pend && !hold_resp) begin
                    if (pend_dly == 0) begin
                        rch = (inject && pend_ch == 5'(inject_ch)) ? pend_ch + 5'd1 : pend_ch;
                        if (fixed && fixed_q.size() != 0) d = fixed_q.pop_front();
                        else d = 12'($urandom);
                        adc.response_valid = 1'b1;
                        adc.response_channel = rch;
                        adc.response_data = d;
                        if (rch == pend_ch) model_sample(pend_ch, d);
                        else inject = 0;
                        exp_done = pend_eop;
                        pend = 0;
                    end else begin
                        pend_dly--;
                    end
                end else if (stray) begin
                    adc.response_valid = 1'b1;
                    adc.response_channel = 5'd0;
                    adc.response_data = 12'hABC;
                    stray = 0;
                end
                case (ready_mode)
                    0: adc.command_ready = ($urandom_range(0, 2) != 0);
                    1: adc.command_ready = 1'b1;
                    default: adc.command_ready = 1'b0;
                endcase
                prev_stall = adc.command_valid && !adc.command_ready;
                prev_ch  = adc.command_channel;
                prev_sop = adc.command_startofpacket;
                prev_eop = adc.command_endofpacket;
                if (adc.command_valid && adc.command_ready) begin
                    acc_cnt++;
                    if (chs.size() == 0) begin
                        check("cmd_unexpected", 32'(adc.command_valid), 32'd0);
                    end else begin
                        check("cmd_ch", 32'(adc.command_channel), 32'(chs[cmd_idx]));
                        check("cmd_sop", 32'(adc.command_startofpacket), 32'(cmd_idx == 0));
                        check("cmd_eop", 32'(adc.command_endofpacket), 32'(cmd_idx == chs.size() - 1));
                        cmd_idx = (cmd_idx + 1) % chs.size();
                    end
                    pend = 1;
                    pend_dly = $urandom_range(0, 3);
                    pend_ch = adc.command_channel;
                    pend_eop = adc.command_endofpacket;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        exp_q.delete();
        cmd_idx = 0;
        for (int i = 0; i < NCH; i++) begin
            mdl_res[i] = '0; macc[i] = 0; mcnt[i] = 0;
        end
    endtask

    task automatic set_mask(input logic [NCH-1:0] m);
        channel_mask = m;
        chs.delete();
        for (int i = 0; i < NCH; i++) if (m[i]) chs.push_back(i);
        cmd_idx = 0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int k = 0; k < 4000 && quiet < 6; k++) begin
            cyc(1);
            if (!adc.command_valid && !pend) quiet++;
            else quiet = 0;
        end
        if (quiet < 6) check("idle_timeout", 32'(quiet), 32'd6);
    endtask

    task automatic run_scans(input int n);
        int k;
        stop_at = done_cnt + n;
        enable = 1'b1;
        for (k = 0; k < 20000 && enable; k++) cyc(1);
        if (enable) begin
            check("scan_timeout", 32'(enable), 32'd0);
            enable = 1'b0;
        end
        wait_idle();
    endtask

    task automatic rd_check(input int c, output logic [11:0] v);
        rd_channel = 5'(c);
        cyc(1);
        v = rd_data;
        check($sformatf("rd_data[%0d]", c), 32'(rd_data), (c < NCH) ? 32'(mdl_res[c]) : 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0, p0, d0, a0, v0, k;
        logic [11:0] v, r2;
        logic [NCH-1:0] m;
        logic [4:0] cch;
        logic csop, ceop;

        do_reset();
        cyc(1);
        check("rst_cmd_valid", 32'(adc.command_valid), 32'd0);
        check("rst_cmd_ch", 32'(adc.command_channel), 32'd0);
        check("rst_sop", 32'(adc.command_startofpacket), 32'd0);
        check("rst_eop", 32'(adc.command_endofpacket), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_sample_ch", 32'(sample_channel), 32'd0);
        check("rst_sample_data", 32'(sample_data), 32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

`ifdef MAX10_ADC_SEQ_AVG_EN
        set_mask(17'h00002);
        fixed = 1;
        fixed_q = '{12'd10, 12'd11, 12'd12, 12'd14};
        s0 = samp_cnt;
        run_scans(4);
        check("avg_count", 32'(samp_cnt - s0), 32'd1);
        check("avg_data", 32'(last_sdata), 32'd11);
        fixed = 0;
`endif

        // Two-channel scan with fixed data
        set_mask(17'h00005);
        ready_mode = 1;
        fixed = 1;
        fixed_q = '{12'h123, 12'h456};
        s0 = samp_cnt; p0 = push_cnt; d0 = done_cnt;
        run_scans(1);
        fixed = 0;
        check("scan_samples", 32'(samp_cnt - s0), 32'(push_cnt - p0));
        check("scan_done_count", 32'(done_cnt - d0), 32'd1);
        rd_check(0, v);
`ifndef MAX10_ADC_SEQ_AVG_EN
        check("direct_rd0", 32'(v), 32'h123);
        check("direct_samples", 32'(samp_cnt - s0), 32'd2);
`endif
        rd_check(2, v);
`ifndef MAX10_ADC_SEQ_AVG_EN
        check("direct_rd2", 32'(v), 32'h456);
`endif

        // Command held off for five cycles
        set_mask(17'h00001);
        ready_mode = 2;
        a0 = acc_cnt;
        enable = 1'b1;
        for (k = 0; k < 20 && !adc.command_valid; k++) cyc(1);
        check("stall_start", 32'(adc.command_valid), 32'd1);
        enable = 1'b0;
        cch = adc.command_channel; csop = adc.command_startofpacket; ceop = adc.command_endofpacket;
        check("stall_first_ch", 32'(cch), 32'd0);
        check("stall_first_sop", 32'(csop), 32'd1);
        check("stall_first_eop", 32'(ceop), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("stall_hold_valid", 32'(adc.command_valid), 32'd1);
            check("stall_hold_ch", 32'(adc.command_channel), 32'(cch));
        end
        ready_mode = 1;
        wait_idle();
        check("stall_accepts", 32'(acc_cnt - a0), 32'd1);

        // Mismatched response channel on ch2
        set_mask(17'h00005);
        r2 = mdl_res[2];
        inject = 1; inject_ch = 2;
        d0 = done_cnt;
        run_scans(1);
        check("mismatch_error", 32'(error), 32'd1);
        check("mismatch_scan_done", 32'(done_cnt - d0), 32'd1);
        rd_check(2, v);
        check("mismatch_reg2", 32'(v), 32'(r2));
        error_clear = 1'b1;
        cyc(1);
        error_clear = 1'b0;
        check("error_cleared", 32'(error), 32'd0);

        // Empty mask never issues
        set_mask('0);
        v0 = valid_cycles;
        enable = 1'b1;
        cyc(100);
        check("zero_mask_valid", 32'(valid_cycles - v0), 32'd0);
        enable = 1'b0;

        // Reset while waiting on a response, then a stray response
        set_mask(17'h00001);
        hold_resp = 1;
        a0 = acc_cnt;
        enable = 1'b1;
        for (k = 0; k < 50 && acc_cnt == a0; k++) cyc(1);
        check("wait_accept", 32'(acc_cnt - a0), 32'd1);
        enable = 1'b0;
        cyc(1);
        do_reset();
        hold_resp = 0;
        stray = 1;
        s0 = samp_cnt;
        cyc(3);
        check("post_rst_cmd_valid", 32'(adc.command_valid), 32'd0);
        check("post_rst_sample_valid", 32'(sample_valid), 32'd0);
        check("post_rst_sample_data", 32'(sample_data), 32'd0);
        check("post_rst_error", 32'(error), 32'd0);
        check("post_rst_samples", 32'(samp_cnt - s0), 32'd0);
        rd_check(0, v);

        // Random masks with random backpressure and response latency
        for (int p = 0; p < 4; p++) begin
            m = NCH'($urandom);
            if (m == '0) m = 17'h10000;
            set_mask(m);
            ready_mode = 0;
            run_scans(5);
            for (int c = 0; c < 19; c++) rd_check(c, v);
            rd_check(31, v);
        end
        ready_mode = 1;
        check("final_error", 32'(error), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
